// File: rtl/period_gen_pkg.sv
// Shared definitions for the period generator: FSM state encodings, default
// microsecond prescale and a counter-width helper.
package period_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int DEFAULT_CLK_US_COUNT = 100;

    // Width of a counter that must hold 0..count-1; never narrower than 1 bit.
    function automatic int width_of(input int count);
        if (count <= 2) begin
            return 1;
        end
        return $clog2(count);
    endfunction

endpackage

// File: rtl/period_generator_us_tick_gen.sv
// Microsecond prescaler: counts clocks 0..CLK_US_COUNT-1 while enabled and
// flags the last clock of each microsecond on tick.
module us_tick_gen
    import period_gen_pkg::*;
#(
    parameter int CLK_US_COUNT = DEFAULT_CLK_US_COUNT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int TW = width_of(CLK_US_COUNT);

    logic [TW-1:0] t_reg;

    assign tick = (t_reg == TW'(CLK_US_COUNT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_reg <= '0;
        end else if (clr) begin
            t_reg <= '0;
        end else if (en) begin
            t_reg <= tick ? '0 : t_reg + TW'(1);
        end
    end

endmodule

// File: rtl/period_generator.sv
// Programmable square-wave source: emits n periods (0 = until stopped) of
// prd microseconds on so. Optional edge_tick output under PERIOD_GEN_EDGE_TICK_EN.
module period_generator
    import period_gen_pkg::*;
#(
    parameter int CLK_US_COUNT = DEFAULT_CLK_US_COUNT,
    parameter int PRD_W        = 20,
    parameter int N_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [PRD_W-1:0] prd,
    input  logic [N_W-1:0]   n,
    output logic             so,
    output logic             ready,
`ifdef PERIOD_GEN_EDGE_TICK_EN
    output logic             edge_tick,
`endif
    output logic             done_tick
);

    state_t           state_reg, state_next;
    logic [PRD_W-1:0] prd_reg, prd_next;
    logic [PRD_W-1:0] u_reg, u_next;
    logic [N_W-1:0]   n_reg, n_next;
    logic             stop_pending_reg, stop_pending_next;
    logic             so_reg;
    logic             t_clr, t_en, us_tick;
    logic [PRD_W-1:0] half_h, half_l;

    us_tick_gen #(
        .CLK_US_COUNT(CLK_US_COUNT)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (t_clr),
        .en    (t_en),
        .tick  (us_tick)
    );

    // Odd periods give the spare microsecond to the low half.
    assign half_h = prd_reg >> 1;
    assign half_l = prd_reg - half_h;

    always_comb begin
        state_next        = state_reg;
        prd_next          = prd_reg;
        u_next            = u_reg;
        n_next            = n_reg;
        stop_pending_next = stop_pending_reg;
        t_clr             = 1'b0;
        t_en              = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    prd_next          = prd;
                    n_next            = n;
                    u_next            = '0;
                    stop_pending_next = 1'b0;
                    t_clr             = 1'b1;
                    state_next        = (prd < PRD_W'(2)) ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                t_en = 1'b1;
                if (stop) begin
                    stop_pending_next = 1'b1;
                end
                if (us_tick) begin
                    if (u_reg == half_h - PRD_W'(1)) begin
                        u_next     = '0;
                        state_next = ST_LOW;
                    end else begin
                        u_next = u_reg + PRD_W'(1);
                    end
                end
            end
            ST_LOW: begin
                t_en = 1'b1;
                if (stop) begin
                    stop_pending_next = 1'b1;
                end
                if (us_tick) begin
                    if (u_reg == half_l - PRD_W'(1)) begin
                        u_next = '0;
                        // A stop sampled on the boundary cycle still ends this period.
                        if (stop_pending_reg || stop || n_reg == N_W'(1)) begin
                            state_next = ST_DONE;
                        end else begin
                            if (n_reg != '0) begin
                                n_next = n_reg - N_W'(1);
                            end
                            state_next = ST_HIGH;
                        end
                    end else begin
                        u_next = u_reg + PRD_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            prd_reg          <= '0;
            u_reg            <= '0;
            n_reg            <= '0;
            stop_pending_reg <= 1'b0;
            so_reg           <= 1'b0;
        end else begin
            state_reg        <= state_next;
            prd_reg          <= prd_next;
            u_reg            <= u_next;
            n_reg            <= n_next;
            stop_pending_reg <= stop_pending_next;
            so_reg           <= (state_next == ST_HIGH);
        end
    end

    assign so        = so_reg;
    assign ready     = (state_reg == ST_IDLE);
    assign done_tick = (state_reg == ST_DONE);

`ifdef PERIOD_GEN_EDGE_TICK_EN
    logic edge_tick_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_tick_reg <= 1'b0;
        end else begin
            edge_tick_reg <= (state_next == ST_HIGH) && (state_reg != ST_HIGH);
        end
    end

    assign edge_tick = edge_tick_reg;
`endif

endmodule

// File: doc/period_generator.md
Name: period_generator

Overview:
- Transmit-side counterpart of the period counter: emits a square wave `so` whose period is a programmed number of microseconds.
- Emits a programmed number of periods (or runs continuously until stopped).
- Uses the same start/ready/done_tick handshake as the measurement blocks.
- Serves as a stimulus source for the low-frequency counter path and as a standalone programmable clock output.

Parameters:
- CLK_US_COUNT, 100, system clocks per 1 us (10 ns clk); TW = clog2(CLK_US_COUNT).
- PRD_W, 20, width of period input in us (up to ~1 s).
- N_W, 8, width of period-count input.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin generation; sampled only in idle.
- stop  in  1  request graceful termination; sampled in high/low.
- prd  in  PRD_W  period in us; latched on accepted start.
- n  in  N_W  periods to emit; 0 = continuous; latched on accepted start.
- so  out  1  generated square wave, registered.
- ready  out  1  high while idle.
- done_tick  out  1  one-cycle pulse when generation ends.

Behaviour:
- Reset values: state=idle, so=0, ready=1, done_tick=0; all counters and latched registers 0, stop_pending=0.
- Reset mid-run aborts immediately: so drops to 0 asynchronously and no done_tick is issued.
- States: idle, high, low, done.
- Half-period split: H = prd>>1, L = prd - H (extra us goes to low half when prd is odd).
- idle:
  - ready=1.
  - On start: latch prd_reg, n_reg; clear t, u and stop_pending.
  - If prd<2, go to done (no waveform). Otherwise go to high.
- so timing:
  - so is registered. It equals 1 exactly in the cycles following a transition into high.
  - The first rising edge of so therefore appears 1 clock after the start cycle.
- high:
  - t counts 0..CLK_US_COUNT-1. At wrap, t returns to 0 and u increments.
  - When t==CLK_US_COUNT-1 and u==H-1: u is cleared, next state is low.
  - Duration is exactly H*CLK_US_COUNT clocks.
- low:
  - Same counting as high, with L. Duration is exactly L*CLK_US_COUNT clocks.
  - At the end of low (period boundary), go to done if stop_pending, or if n_reg!=0 and n_reg==1.
  - Otherwise decrement n_reg when nonzero and go to high.
- One full period is exactly prd*CLK_US_COUNT clocks, with no gap between periods.
- stop:
  - Any stop sample in high/low sets stop_pending.
  - Generation ends at the next period boundary; a partial period is never truncated.
  - stop is ignored in idle and done.
- done: done_tick=1 for exactly one cycle, so=0, next state idle.
- Simultaneous events:
  - start together with stop in idle: start is accepted and stop is ignored.
  - stop on the final boundary cycle: result is identical to normal completion, with a single done_tick.
- prd/n changes during a run have no effect until the next accepted start.
- Arithmetic:
  - All counters are unsigned.
  - u is PRD_W bits, t is TW bits, n_reg is N_W bits, and none of them wrap past their terminal compare.
  - Continuous mode (n=0) never decrements n_reg.

Optional Feature:
- Macro PERIOD_GEN_EDGE_TICK_EN.
- When defined:
  - Adds output edge_tick (1 bit, reset 0).
  - edge_tick pulses for one cycle coincident with the first cycle of so=1 in every period.
  - This gives a loopback reference for the period counter.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package period_gen_pkg holds:
  - State encodings: idle=2'b00, high=2'b01, low=2'b10, done=2'b11.
  - Default CLK_US_COUNT.
  - A clog2-based width function.
- One sub-module, us_tick_gen:
  - Owns t, with sync clear input and tick output at t==CLK_US_COUNT-1.
  - The FSMD instantiates it and keeps u, n_reg and stop_pending.

Test Plan (CLK_US_COUNT=4):
- Reset low mid-high-phase -> so=0 at once, ready=1 after release, no done_tick.
- start, prd=5, n=2 -> so rises 1 clk after start; high 8 clks, low 12 clks; two periods (40 clks); done_tick 1 clk later; ready returns the following cycle.
- start, prd=4, n=0, stop asserted 10 clks into the 2nd period -> 2nd period completes (16 clks each), then done_tick; no 3rd rising edge.
- start, prd=1, n=3 -> so stays 0, done_tick on the cycle after start, then idle.
- During a prd=6, n=1 run: toggle start and change prd to 2 -> ignored; single 24-clk period; ready=0 throughout the run.
- With PERIOD_GEN_EDGE_TICK_EN: prd=3, n=3 -> edge_tick pulses 3 times, 12 clks apart, each aligned to so's rising edge.
